// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every bus signal of the memory port arbiter: the instruction-fetch
// request port, the data-memory request port, the shared single-port memory
// interface and the per-port stall / busy indications.
//   slave  : the arbiter's view (requests and mem_rdata in; responses,
//            memory controls, stalls and busy out)
//   master : the opposite view, taken by the pipeline/memory side
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   // data port
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   // shared memory
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   // hazard / status
   logic              stall_if;
   logic              stall_mem;
   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid,
             mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid,
             mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port and the data-memory port. Requests are serialised with alternating
// priority on ties; each access runs IDLE -> ISSUE -> (WAIT) -> RESP and
// finishes with a one-cycle valid pulse to its owner.
// Ports:
//   clk     : clock
//   reset   : asynchronous, active-high reset
//   arb_bus : mem_port_arbiter_if.slave - fetch port (if_*), data port (dm_*),
//             memory port (mem_*), stall_if, stall_mem, busy
// Parameters: ADDR_W, DATA_W, LAT (memory read latency 1..15, counted from
// the mem_en cycle to the cycle mem_rdata is valid).
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.slave  arb_bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

   // WAIT lasts LAT cycles; the counter runs LAT-1 down to 0 and the read
   // data is captured in the cycle it reaches 0.
   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_owner_q, last_owner_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic              grant_data;

   // Data wins when it is the only requester, or on a tie when fetch owned
   // the previous grant.
   assign grant_data = arb_bus.dm_req &
                       (~arb_bus.if_req | (last_owner_q == FETCH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= FETCH;
         last_owner_q <= FETCH;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         if_valid_q   <= 1'b0;
         dm_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         if_valid_q   <= if_valid_d;
         dm_valid_q   <= dm_valid_d;
      end
   end

   // Registered outputs are computed one cycle ahead: mem_en_d is raised on
   // the grant so mem_en is high during ISSUE, and the valid_d pulses are
   // raised on the transition into RESP.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      if_valid_d   = 1'b0;
      dm_valid_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_bus.if_req || arb_bus.dm_req) begin
               owner_d      = grant_data ? DATA : FETCH;
               last_owner_d = grant_data ? DATA : FETCH;
               mem_en_d     = 1'b1;
               // fetch never writes
               mem_we_d     = grant_data & arb_bus.dm_we;
               mem_addr_d   = grant_data ? arb_bus.dm_addr : arb_bus.if_addr;
               mem_wdata_d  = arb_bus.dm_wdata;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_we_q) begin
               dm_valid_d = 1'b1;
               state_d    = RESP;
            end else begin
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (owner_q == DATA) begin
                  dm_rdata_d = arb_bus.mem_rdata;
                  dm_valid_d = 1'b1;
               end else begin
                  if_rdata_d = arb_bus.mem_rdata;
                  if_valid_d = 1'b1;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            // requests are deliberately not sampled here
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign arb_bus.mem_en    = mem_en_q;
   assign arb_bus.mem_we    = mem_we_q;
   assign arb_bus.mem_addr  = mem_addr_q;
   assign arb_bus.mem_wdata = mem_wdata_q;
   assign arb_bus.if_rdata  = if_rdata_q;
   assign arb_bus.if_valid  = if_valid_q;
   assign arb_bus.dm_rdata  = dm_rdata_q;
   assign arb_bus.dm_valid  = dm_valid_q;
   assign arb_bus.stall_if  = arb_bus.if_req & ~if_valid_q;
   assign arb_bus.stall_mem = arb_bus.dm_req & ~dm_valid_q;
   assign arb_bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboarded bench for mem_port_arbiter. A LAT=2 instance gets the full
// sequence (tie after reset, data read/write/read-back, fetch read, sustained
// alternation, reset during WAIT); LAT=1 and LAT=15 instances each do a single
// fetch read. Each instance sees a behavioural fixed-latency memory.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b15 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(2))
      dut (.clk(clk), .reset(reset), .arb_bus(bus.slave));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1))
      dut_l1 (.clk(clk), .reset(reset), .arb_bus(b1.slave));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(15))
      dut_l15 (.clk(clk), .reset(reset), .arb_bus(b15.slave));

   // ---------------- memory models ----------------
   logic [DW-1:0] mem [logic [AW-1:0]];

   function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      if (a == 32'h0040_0000) return 32'h8C08_0004;
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
      return a ^ 32'hC3C3_3C3C;
   endfunction

   logic [DW-1:0] pipe2 [2];
   logic [DW-1:0] pipe1;
   logic [DW-1:0] pipe15 [15];

   always @(posedge clk) begin
      pipe2[0] <= (bus.mem_en && !bus.mem_we) ? mem_read(bus.mem_addr) : 32'hDEAD_BEEF;
      pipe2[1] <= pipe2[0];
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      pipe1     <= (b1.mem_en && !b1.mem_we) ? rom(b1.mem_addr) : 32'hDEAD_BEEF;
      pipe15[0] <= (b15.mem_en && !b15.mem_we) ? rom(b15.mem_addr) : 32'hDEAD_BEEF;
      for (int i = 1; i < 15; i++) pipe15[i] <= pipe15[i-1];
   end

   assign bus.mem_rdata = pipe2[1];
   assign b1.mem_rdata  = pipe1;
   assign b15.mem_rdata = pipe15[14];

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      int            cyc;
   } mem_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } rsp_exp_t;

   mem_exp_t mem_q [$];
   rsp_exp_t if_q [$];
   rsp_exp_t dm_q [$];
   logic [DW-1:0] dm_model;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      mem_exp_t me;
      rsp_exp_t re;
      if (!reset) begin
         if (bus.mem_en) begin
            if (mem_q.size() == 0) check_val("mem_en_unexpected", 64'd1, 64'd0);
            else begin
               me = mem_q.pop_front();
               $display("[TB] cyc %0d mem access addr=0x%08h we=%0b", cyc, bus.mem_addr, bus.mem_we);
               check_val("mem_addr", bus.mem_addr, me.addr);
               check_val("mem_we", bus.mem_we, me.we);
               if (me.we) check_val("mem_wdata", bus.mem_wdata, me.wdata);
               check_val("mem_en_cycle", cyc, me.cyc);
            end
         end
         if (bus.if_valid) begin
            if (if_q.size() == 0) check_val("if_valid_unexpected", 64'd1, 64'd0);
            else begin
               re = if_q.pop_front();
               $display("[TB] cyc %0d fetch done rdata=0x%08h", cyc, bus.if_rdata);
               check_val("if_rdata", bus.if_rdata, re.data);
               check_val("if_valid_cycle", cyc, re.cyc);
            end
         end
         if (bus.dm_valid) begin
            if (dm_q.size() == 0) check_val("dm_valid_unexpected", 64'd1, 64'd0);
            else begin
               re = dm_q.pop_front();
               $display("[TB] cyc %0d data done rdata=0x%08h", cyc, bus.dm_rdata);
               check_val("dm_rdata", bus.dm_rdata, re.data);
               check_val("dm_valid_cycle", cyc, re.cyc);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Entered at the negedge the request was raised; returns at the negedge
   // after the completion cycle, when the DUT is back in IDLE.
   task automatic wait_valid(input bit is_dm, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #1;
         if (is_dm ? bus.dm_valid : bus.if_valid) begin
            seen = 1'b1;
            check_val({tag, "_stall_at_valid"}, is_dm ? bus.stall_mem : bus.stall_if, 64'd0);
         end else begin
            check_val({tag, "_stall_pending"}, is_dm ? bus.stall_mem : bus.stall_if, 64'd1);
            @(negedge clk);
         end
      end
      if (!seen) check_val({tag, "_timeout"}, 64'd0, 64'd1);
      if (is_dm) bus.dm_req = 1'b0;
      else       bus.if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic dm_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      int t;
      t = cyc;
      bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata; bus.dm_req = 1'b1;
      mem_q.push_back(mem_exp_t'{addr, we, wdata, t + 1});
      if (!we) dm_model = mem_read(addr);
      dm_q.push_back(rsp_exp_t'{dm_model, we ? t + 2 : t + 4});
      wait_valid(1'b1, we ? "dm_write" : "dm_read");
   endtask

   task automatic if_read(input logic [AW-1:0] addr);
      int t;
      t = cyc;
      bus.if_addr = addr; bus.if_req = 1'b1;
      mem_q.push_back(mem_exp_t'{addr, 1'b0, '0, t + 1});
      if_q.push_back(rsp_exp_t'{mem_read(addr), t + 4});
      wait_valid(1'b0, "if_read");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t, nd, nf;
      bit got1, got15;
      reset = 1'b1;
      dm_model = '0;
      bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
      b1.if_req = 0;  b1.if_addr = '0;  b1.dm_req = 0;  b1.dm_we = 0;  b1.dm_addr = '0;  b1.dm_wdata = '0;
      b15.if_req = 0; b15.if_addr = '0; b15.dm_req = 0; b15.dm_we = 0; b15.dm_addr = '0; b15.dm_wdata = '0;
      repeat (3) @(negedge clk);
      check_val("rst_mem_en", bus.mem_en, 64'd0);
      check_val("rst_mem_addr", bus.mem_addr, 64'd0);
      check_val("rst_if_valid", bus.if_valid, 64'd0);
      check_val("rst_dm_rdata", bus.dm_rdata, 64'd0);
      check_val("rst_busy", bus.busy, 64'd0);
      check_val("rst_stall_if", bus.stall_if, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // tie right after reset: data first, then fetch
      t = cyc;
      bus.if_addr = 32'h0040_0000; bus.dm_addr = 32'h0000_0010; bus.dm_we = 1'b0;
      bus.if_req = 1'b1; bus.dm_req = 1'b1;
      mem_q.push_back(mem_exp_t'{32'h0000_0010, 1'b0, '0, t + 1});
      dm_q.push_back(rsp_exp_t'{mem_read(32'h0000_0010), t + 4});
      mem_q.push_back(mem_exp_t'{32'h0040_0000, 1'b0, '0, t + 6});
      if_q.push_back(rsp_exp_t'{32'h8C08_0004, t + 9});
      dm_model = mem_read(32'h0000_0010);
      for (int i = 0; i <= 9; i++) begin
         #1;
         check_val("tie_stall_if", bus.stall_if, (i < 9) ? 64'd1 : 64'd0);
         check_val("tie_stall_mem", bus.stall_mem, (i < 4) ? 64'd1 : 64'd0);
         if (bus.dm_valid) bus.dm_req = 1'b0;
         if (bus.if_valid) bus.if_req = 1'b0;
         @(negedge clk);
      end

      // data read, write (rdata must hold), read-back, then a fetch
      dm_access(1'b0, 32'h1000_0020, 32'h0);
      dm_access(1'b1, 32'h4000_0010, 32'h0000_ABCD);
      dm_access(1'b0, 32'h4000_0010, 32'h0);
      check_val("readback_value", dm_model, 64'h0000_ABCD);
      if_read(32'h0040_0000);

      // both held: strict D,F,D,F,D,F
      t = cyc;
      bus.dm_addr = 32'h1000_0040; bus.dm_we = 1'b0; bus.if_addr = 32'h0040_0008;
      bus.dm_req = 1'b1; bus.if_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            mem_q.push_back(mem_exp_t'{32'h1000_0040, 1'b0, '0, t + 5*k + 1});
            dm_q.push_back(rsp_exp_t'{mem_read(32'h1000_0040), t + 5*k + 4});
         end else begin
            mem_q.push_back(mem_exp_t'{32'h0040_0008, 1'b0, '0, t + 5*k + 1});
            if_q.push_back(rsp_exp_t'{mem_read(32'h0040_0008), t + 5*k + 4});
         end
      end
      dm_model = mem_read(32'h1000_0040);
      nd = 0; nf = 0;
      for (int i = 0; i < 60 && (nd < 3 || nf < 3); i++) begin
         @(negedge clk); #1;
         if (bus.dm_valid) begin nd++; if (nd == 3) bus.dm_req = 1'b0; end
         if (bus.if_valid) begin nf++; if (nf == 3) bus.if_req = 1'b0; end
      end
      check_val("alt_dm_count", nd, 64'd3);
      check_val("alt_if_count", nf, 64'd3);
      @(negedge clk);

      // reset during WAIT of a fetch read
      t = cyc;
      bus.if_addr = 32'h0040_0010; bus.if_req = 1'b1;
      mem_q.push_back(mem_exp_t'{32'h0040_0010, 1'b0, '0, t + 1});
      @(negedge clk); @(negedge clk);
      check_val("pre_reset_busy", bus.busy, 64'd1);
      #2 reset = 1'b1;
      #1;
      check_val("arst_mem_en", bus.mem_en, 64'd0);
      check_val("arst_mem_addr", bus.mem_addr, 64'd0);
      check_val("arst_if_rdata", bus.if_rdata, 64'd0);
      check_val("arst_dm_rdata", bus.dm_rdata, 64'd0);
      check_val("arst_busy", bus.busy, 64'd0);
      check_val("arst_stall_if", bus.stall_if, 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("arst_no_if_valid", bus.if_valid, 64'd0);
         check_val("arst_busy_hold", bus.busy, 64'd0);
      end
      reset = 1'b0;
      dm_model = '0;
      t = cyc;
      mem_q.push_back(mem_exp_t'{32'h0040_0010, 1'b0, '0, t + 1});
      if_q.push_back(rsp_exp_t'{mem_read(32'h0040_0010), t + 4});
      wait_valid(1'b0, "restart");

      // LAT=1 and LAT=15 instances, one fetch read each
      t = cyc; got1 = 1'b0; got15 = 1'b0;
      b1.if_addr = 32'h0000_1000; b1.if_req = 1'b1;
      b15.if_addr = 32'h0000_2000; b15.if_req = 1'b1;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         if (b1.if_valid) begin
            $display("[TB] cyc %0d lat1 fetch done rdata=0x%08h", cyc, b1.if_rdata);
            check_val("lat1_cycle", cyc, t + 3);
            check_val("lat1_rdata", b1.if_rdata, rom(32'h0000_1000));
            b1.if_req = 1'b0; got1 = 1'b1;
         end
         if (b15.if_valid) begin
            $display("[TB] cyc %0d lat15 fetch done rdata=0x%08h", cyc, b15.if_rdata);
            check_val("lat15_cycle", cyc, t + 17);
            check_val("lat15_rdata", b15.if_rdata, rom(32'h0000_2000));
            b15.if_req = 1'b0; got15 = 1'b1;
         end
      end
      check_val("lat1_seen", got1, 64'd1);
      check_val("lat15_seen", got15, 64'd1);

      repeat (3) @(negedge clk);
      check_val("mem_q_drained", mem_q.size(), 64'd0);
      check_val("if_q_drained", if_q.size(), 64'd0);
      check_val("dm_q_drained", dm_q.size(), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
